// File: rtl/bip_debug_tx.sv
// Debug reporter: on a rising wr_uart (CPU halted) snapshot PC, ACC and a cycle
// counter, then stream them as a byte frame into a UART TX. Define DBG_CHECKSUM_EN for an XOR trailer byte.
module bip_debug_tx #(
  parameter int PC_W   = 11,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_uart,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] acc,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              done
);

`ifdef DBG_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd9;
`else
  localparam logic [3:0] LAST_IDX = 4'd8;
`endif

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              hist_q;
  logic [15:0]       pcSnap_q;
  logic [15:0]       accSnap_q;
  logic [CNT_W-1:0]  cntSnap_q;
  logic              loaded_q;
  logic              latchSnap;
  logic              trigger;
  logic [7:0]        frameByte;

  assign trigger = wr_uart & ~hist_q;

  // Free-running cycle counter, frozen while halted and saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      hist_q <= 1'b0;
    end else begin
      hist_q <= wr_uart;
      if (!wr_uart && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      pcSnap_q  <= 16'h0000;
      accSnap_q <= 16'h0000;
      cntSnap_q <= '0;
      loaded_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (latchSnap) begin
        pcSnap_q  <= 16'(pc);
        accSnap_q <= acc;
        cntSnap_q <= cnt_q;
        loaded_q  <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    latchSnap = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          latchSnap = 1'b1;
          idx_d     = 4'd0;
          state_d   = SEND;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = SEND;
          end
        end
      end
      DONE: begin
        if (!wr_uart)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DBG_CHECKSUM_EN
  logic [7:0] checksum;
  assign checksum = 8'hA5 ^ pcSnap_q[15:8] ^ pcSnap_q[7:0] ^ accSnap_q[15:8] ^ accSnap_q[7:0]
                  ^ cntSnap_q[31:24] ^ cntSnap_q[23:16] ^ cntSnap_q[15:8] ^ cntSnap_q[7:0];
`endif

  // The byte is selected straight from the held snapshot, so it stays stable through WAIT.
  always_comb begin
    frameByte = 8'h00;
    case (idx_q)
      4'd0: frameByte = 8'hA5;
      4'd1: frameByte = pcSnap_q[15:8];
      4'd2: frameByte = pcSnap_q[7:0];
      4'd3: frameByte = accSnap_q[15:8];
      4'd4: frameByte = accSnap_q[7:0];
      4'd5: frameByte = cntSnap_q[31:24];
      4'd6: frameByte = cntSnap_q[23:16];
      4'd7: frameByte = cntSnap_q[15:8];
      4'd8: frameByte = cntSnap_q[7:0];
`ifdef DBG_CHECKSUM_EN
      4'd9: frameByte = checksum;
`endif
      default: frameByte = 8'h00;
    endcase
  end

  assign tx_start = (state_q == SEND);
  assign tx_data  = loaded_q ? frameByte : 8'h00;
  assign busy     = (state_q == SEND) || (state_q == WAIT);
  assign done     = (state_q == DONE);

endmodule
